// File: rtl/vga_timing_pattern_if.sv
// VGA pattern generator port bundle: mode select in, sync/colour/position out.
interface vga_timing_pattern_if #(
  parameter int unsigned COLOR_BITS = 4
);
  logic [1:0]            mode_i;
  logic                  vga_hsync_o;
  logic                  vga_vsync_o;
  logic [COLOR_BITS-1:0] vga_red_o;
  logic [COLOR_BITS-1:0] vga_green_o;
  logic [COLOR_BITS-1:0] vga_blue_o;
  logic                  visible_o;
  logic                  frame_start_o;
  logic [15:0]           h_count_o;
  logic [15:0]           v_count_o;

  modport master (
    input  mode_i,
    output vga_hsync_o, vga_vsync_o, vga_red_o, vga_green_o, vga_blue_o,
           visible_o, frame_start_o, h_count_o, v_count_o
  );

  modport slave (
    output mode_i,
    input  vga_hsync_o, vga_vsync_o, vga_red_o, vga_green_o, vga_blue_o,
           visible_o, frame_start_o, h_count_o, v_count_o
  );
endinterface

// File: rtl/vga_timing_pattern.sv
// VGA timing generator with four selectable test patterns; all outputs
// are registered one cycle behind the h/v counter state they describe.
module vga_timing_pattern #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned COLOR_BITS = 4
) (
  input logic clk,
  input logic reset,
  vga_timing_pattern_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS        = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS        = 16'(V_VISIBLE);
  localparam logic [15:0] H_VIS_LAST   = 16'(H_VISIBLE - 1);
  localparam logic [15:0] V_VIS_LAST   = 16'(V_VISIBLE - 1);
  localparam logic [15:0] H_SYNC_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] H_SYNC_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] V_SYNC_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] V_SYNC_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [15:0] BAR_W        = 16'(H_VISIBLE / 8);

  localparam logic [COLOR_BITS-1:0] ONES = '1;

  // Reject parameter sets that cannot produce a sane raster.
  if (COLOR_BITS < 1 || COLOR_BITS > 8 || (H_VISIBLE % 8) != 0 ||
      H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
      H_TOTAL > 65536 || V_TOTAL > 65536) begin : g_bad_params
    $error("vga_timing_pattern: illegal parameter set");
  end

  logic [15:0]           h_cnt;
  logic [15:0]           v_cnt;
  logic [1:0]            active_mode;

  logic                  h_last;
  logic                  v_last;
  logic                  frame_first;
  logic [1:0]            cur_mode;
  logic [2:0]            bar;
  logic                  vis_nxt;
  logic                  hsync_nxt;
  logic                  vsync_nxt;
  logic [COLOR_BITS-1:0] red_nxt;
  logic [COLOR_BITS-1:0] green_nxt;
  logic [COLOR_BITS-1:0] blue_nxt;

  // Decode the current counter state into next output values.
  always_comb begin
    h_last      = (h_cnt == H_LAST);
    v_last      = (v_cnt == V_LAST);
    frame_first = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    // The frame-start pixel already uses the freshly sampled mode.
    cur_mode    = frame_first ? vga.mode_i : active_mode;
    vis_nxt     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_nxt   = (h_cnt >= H_SYNC_START && h_cnt < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_nxt   = (v_cnt >= V_SYNC_START && v_cnt < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
    bar         = 3'(h_cnt / BAR_W);
    red_nxt     = '0;
    green_nxt   = '0;
    blue_nxt    = '0;
    if (vis_nxt) begin
      unique case (cur_mode)
        2'd0: begin
          red_nxt   = bar[0] ? ONES : '0;
          green_nxt = bar[1] ? ONES : '0;
          blue_nxt  = bar[2] ? ONES : '0;
        end
        2'd1: begin
          if (h_cnt[5] ^ v_cnt[5]) begin
            red_nxt   = ONES;
            green_nxt = ONES;
            blue_nxt  = ONES;
          end
        end
        2'd2: begin
          red_nxt   = h_cnt[COLOR_BITS+3:4];
          green_nxt = v_cnt[COLOR_BITS+3:4];
        end
        default: begin
          if (h_cnt == 16'd0 || h_cnt == H_VIS_LAST ||
              v_cnt == 16'd0 || v_cnt == V_VIS_LAST) begin
            red_nxt   = ONES;
            green_nxt = ONES;
            blue_nxt  = ONES;
          end
        end
      endcase
    end
  end

  // Raster counters and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= 16'd0;
      v_cnt       <= 16'd0;
      active_mode <= 2'd0;
    end else begin
      if (frame_first) begin
        active_mode <= vga.mode_i;
      end
      if (h_last) begin
        h_cnt <= 16'd0;
        v_cnt <= v_last ? 16'd0 : v_cnt + 16'd1;
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga.vga_hsync_o   <= ~H_SYNC_POL;
      vga.vga_vsync_o   <= ~V_SYNC_POL;
      vga.vga_red_o     <= '0;
      vga.vga_green_o   <= '0;
      vga.vga_blue_o    <= '0;
      vga.visible_o     <= 1'b0;
      vga.frame_start_o <= 1'b0;
      vga.h_count_o     <= 16'd0;
      vga.v_count_o     <= 16'd0;
    end else begin
      vga.vga_hsync_o   <= hsync_nxt;
      vga.vga_vsync_o   <= vsync_nxt;
      vga.vga_red_o     <= red_nxt;
      vga.vga_green_o   <= green_nxt;
      vga.vga_blue_o    <= blue_nxt;
      vga.visible_o     <= vis_nxt;
      vga.frame_start_o <= frame_first;
      vga.h_count_o     <= h_cnt;
      vga.v_count_o     <= v_cnt;
    end
  end

endmodule
